// File: rtl/bus_stable_filter.sv
// bus_stable_filter
// Qualifies a raw multi-bit bus before it reaches the bus delay line. The raw
// bus is registered every cycle. A new value is forwarded to outbus only after
// it has been seen on the registered bus for STABLE_CYCLES consecutive cycles.
// Every accepted change produces a one-cycle upd_pulse. Every aborted or
// restarted candidate is counted in a saturating glitch counter.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          qualification enable
//   force_ld    load the registered bus straight to outbus, bypassing qualification
//   glitch_clr  synchronous clear of glitch_cnt (wins over an increment)
//   inbus       raw bus
//   outbus      qualified, registered bus
//   upd_pulse   one-cycle pulse whenever outbus takes a new value
//   qualifying  high while a candidate is being qualified
//   glitch_cnt  saturating count of aborted or restarted candidates

module bus_stable_filter #(
   parameter int                   BUS_WIDTH     = 8,
   parameter int                   STABLE_CYCLES = 4,
   parameter int                   CNT_WIDTH     = 8,
   parameter logic [BUS_WIDTH-1:0] INIT_VAL      = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 force_ld,
   input  logic                 glitch_clr,
   input  logic [BUS_WIDTH-1:0] inbus,
   output logic [BUS_WIDTH-1:0] outbus,
   output logic                 upd_pulse,
   output logic                 qualifying,
   output logic [7:0]           glitch_cnt
);

   typedef enum logic {
      IDLE,
      QUAL
   } state_t;

   // The candidate is accepted on the cycle where it is seen for the
   // STABLE_CYCLES-th time, i.e. when the counter already holds STABLE_CYCLES-1.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t               state;
   state_t               state_nxt;
   logic [BUS_WIDTH-1:0] in_q;
   logic [BUS_WIDTH-1:0] cand;
   logic [BUS_WIDTH-1:0] cand_nxt;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_nxt;
   logic [BUS_WIDTH-1:0] outbus_nxt;
   logic                 upd_nxt;
   logic                 glitch_inc;

   // Input register: every decision is made on the registered bus so the
   // comparison logic never sees the raw, possibly asynchronous, input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q <= INIT_VAL;
      end else begin
         in_q <= inbus;
      end
   end

   // State, candidate, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cand      <= INIT_VAL;
         cnt       <= '0;
         outbus    <= INIT_VAL;
         upd_pulse <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         cnt       <= cnt_nxt;
         outbus    <= outbus_nxt;
         upd_pulse <= upd_nxt;
      end
   end

   // Next-state logic. force_ld beats en, and en=0 simply parks the block in
   // IDLE without counting the dropped candidate as a glitch.
   always_comb begin
      state_nxt  = state;
      cand_nxt   = cand;
      cnt_nxt    = cnt;
      outbus_nxt = outbus;
      upd_nxt    = 1'b0;
      glitch_inc = 1'b0;

      if (force_ld) begin
         outbus_nxt = in_q;
         upd_nxt    = (in_q != outbus);
         state_nxt  = IDLE;
         cnt_nxt    = '0;
      end else if (!en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_q != outbus) begin
                  // A single required sample means the first sighting is enough.
                  if (STABLE_CYCLES == 1) begin
                     outbus_nxt = in_q;
                     upd_nxt    = 1'b1;
                     cnt_nxt    = '0;
                  end else begin
                     cand_nxt  = in_q;
                     cnt_nxt   = CNT_ONE;
                     state_nxt = QUAL;
                  end
               end
            end
            QUAL: begin
               if (in_q == cand) begin
                  if (cnt == CNT_LAST) begin
                     outbus_nxt = cand;
                     upd_nxt    = 1'b1;
                     state_nxt  = IDLE;
                     cnt_nxt    = '0;
                  end else begin
                     cnt_nxt = cnt + CNT_ONE;
                  end
               end else if (in_q == outbus) begin
                  // Bus fell back to the current output: the candidate was a glitch.
                  state_nxt  = IDLE;
                  cnt_nxt    = '0;
                  glitch_inc = 1'b1;
               end else begin
                  // A third value appeared: drop the candidate and restart on it.
                  cand_nxt   = in_q;
                  cnt_nxt    = CNT_ONE;
                  glitch_inc = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Saturating glitch counter; a clear in the same cycle as an abort wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt <= 8'h00;
      end else if (glitch_clr) begin
         glitch_cnt <= 8'h00;
      end else if (glitch_inc && (glitch_cnt != 8'hFF)) begin
         glitch_cnt <= glitch_cnt + 8'h01;
      end
   end

   assign qualifying = (state == QUAL);

endmodule

// File: tb/tb_bus_stable_filter.sv
// tb_bus_stable_filter
// Self-checking bench for bus_stable_filter. A STABLE_CYCLES=4 instance is
// driven through applyStimulus, which pushes the expected post-edge outputs
// of a behavioural model onto a scoreboard queue and pops/compares them after
// the edge. Directed constant checks cover the step latency, glitch reject,
// restart, force_ld/en, saturation/clear and reset mid-qualification. A second
// STABLE_CYCLES=1 instance checks continuous pulses with a two-edge latency.

module tb_bus_stable_filter;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       force_ld;
   logic       glitch_clr;
   logic [7:0] inbus;
   logic [7:0] outbus;
   logic       upd_pulse;
   logic       qualifying;
   logic [7:0] glitch_cnt;

   logic       en_f;
   logic       force_f;
   logic       clr_f;
   logic [7:0] inbus_f;
   logic [7:0] outbus_f;
   logic       upd_f;
   logic       qual_f;
   logic [7:0] glitch_f;

   typedef struct {
      logic [7:0] out;
      logic       upd;
      logic       qual;
      logic [7:0] glitch;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] fast_q[$];

   int check_count = 0;
   int pass_count  = 0;

   // Behavioural reference state for the STABLE_CYCLES=4 instance.
   logic [7:0] m_in_q;
   logic [7:0] m_cand;
   int         m_cnt;
   logic       m_qual;
   logic [7:0] m_out;
   logic       m_upd;
   int         m_glitch;

   logic upd_seen;
   logic saw_11;

   bus_stable_filter #(
      .BUS_WIDTH    (8),
      .STABLE_CYCLES(4),
      .CNT_WIDTH    (8),
      .INIT_VAL     (8'h00)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .force_ld  (force_ld),
      .glitch_clr(glitch_clr),
      .inbus     (inbus),
      .outbus    (outbus),
      .upd_pulse (upd_pulse),
      .qualifying(qualifying),
      .glitch_cnt(glitch_cnt)
   );

   bus_stable_filter #(
      .BUS_WIDTH    (8),
      .STABLE_CYCLES(1),
      .CNT_WIDTH    (8),
      .INIT_VAL     (8'h00)
   ) u_dut_fast (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en_f),
      .force_ld  (force_f),
      .glitch_clr(clr_f),
      .inbus     (inbus_f),
      .outbus    (outbus_f),
      .upd_pulse (upd_f),
      .qualifying(qual_f),
      .glitch_cnt(glitch_f)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_count++;
      if (obs !== exp) begin
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         pass_count++;
      end
   endtask

   task automatic resetModel();
      m_in_q   = 8'h00;
      m_cand   = 8'h00;
      m_cnt    = 0;
      m_qual   = 1'b0;
      m_out    = 8'h00;
      m_upd    = 1'b0;
      m_glitch = 0;
   endtask

   // Advances the reference by one edge using the inputs about to be sampled.
   task automatic modelStep(input logic [7:0] bus, input logic e, input logic f, input logic c);
      logic [7:0] n_out;
      logic [7:0] n_cand;
      logic       n_upd;
      logic       n_qual;
      int         n_cnt;
      logic       inc;
      n_out  = m_out;
      n_cand = m_cand;
      n_upd  = 1'b0;
      n_qual = m_qual;
      n_cnt  = m_cnt;
      inc    = 1'b0;
      if (f) begin
         n_out  = m_in_q;
         n_upd  = (m_in_q != m_out);
         n_qual = 1'b0;
         n_cnt  = 0;
      end else if (!e) begin
         n_qual = 1'b0;
         n_cnt  = 0;
      end else if (!m_qual) begin
         if (m_in_q != m_out) begin
            n_cand = m_in_q;
            n_cnt  = 1;
            n_qual = 1'b1;
         end
      end else if (m_in_q == m_cand) begin
         if (m_cnt + 1 == 4) begin
            n_out  = m_cand;
            n_upd  = 1'b1;
            n_qual = 1'b0;
            n_cnt  = 0;
         end else begin
            n_cnt = m_cnt + 1;
         end
      end else if (m_in_q == m_out) begin
         n_qual = 1'b0;
         n_cnt  = 0;
         inc    = 1'b1;
      end else begin
         n_cand = m_in_q;
         n_cnt  = 1;
         inc    = 1'b1;
      end
      if (c) begin
         m_glitch = 0;
      end else if (inc && m_glitch < 255) begin
         m_glitch = m_glitch + 1;
      end
      m_out  = n_out;
      m_cand = n_cand;
      m_upd  = n_upd;
      m_qual = n_qual;
      m_cnt  = n_cnt;
      m_in_q = bus;
   endtask

   // Drives one cycle of inputs just after an edge, queues the expected
   // result, then compares the DUT one time unit after the next edge.
   task automatic applyStimulus(input logic [7:0] bus, input logic e, input logic f, input logic c);
      exp_t ex;
      inbus      = bus;
      en         = e;
      force_ld   = f;
      glitch_clr = c;
      modelStep(bus, e, f, c);
      ex.out    = m_out;
      ex.upd    = m_upd;
      ex.qual   = m_qual;
      ex.glitch = m_glitch[7:0];
      sb_q.push_back(ex);
      @(posedge clk);
      #1;
      ex = sb_q.pop_front();
      checkOutput("sb_outbus", 32'(outbus), 32'(ex.out));
      checkOutput("sb_upd", 32'(upd_pulse), 32'(ex.upd));
      checkOutput("sb_qual", 32'(qualifying), 32'(ex.qual));
      checkOutput("sb_glitch", 32'(glitch_cnt), 32'(ex.glitch));
      if (upd_pulse) upd_seen = 1'b1;
      if (outbus == 8'h11) saw_11 = 1'b1;
   endtask

   initial begin
      rst_n      = 1'b0;
      en         = 1'b1;
      force_ld   = 1'b0;
      glitch_clr = 1'b0;
      inbus      = 8'h00;
      en_f       = 1'b1;
      force_f    = 1'b0;
      clr_f      = 1'b0;
      inbus_f    = 8'h00;
      upd_seen   = 1'b0;
      saw_11     = 1'b0;
      resetModel();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_outbus", 32'(outbus), 32'h00);
      checkOutput("rst_upd", 32'(upd_pulse), 32'h0);
      checkOutput("rst_qual", 32'(qualifying), 32'h0);
      checkOutput("rst_glitch", 32'(glitch_cnt), 32'h00);
      rst_n = 1'b1;

      // Step to A5: held through edges 2-4, accepted at edge 5, pulse drops at 6
      for (int e = 1; e <= 7; e++) begin
         applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
         if (e >= 2 && e <= 4) begin
            checkOutput("step_hold", 32'(outbus), 32'h00);
            checkOutput("step_qual", 32'(qualifying), 32'h1);
         end
         if (e == 5) begin
            checkOutput("step_out", 32'(outbus), 32'hA5);
            checkOutput("step_upd", 32'(upd_pulse), 32'h1);
         end
         if (e == 6) checkOutput("step_upd_fall", 32'(upd_pulse), 32'h0);
      end

      // Return to 00 so the glitch test starts from a zero output
      for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("back_to_00", 32'(outbus), 32'h00);

      // Glitch reject: one cycle of 3C
      upd_seen = 1'b0;
      applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("glitch_out", 32'(outbus), 32'h00);
      checkOutput("glitch_no_upd", 32'(upd_seen), 32'h0);
      checkOutput("glitch_cnt1", 32'(glitch_cnt), 32'h01);

      // Restart: 11 for two cycles, then 22 held
      saw_11 = 1'b0;
      for (int i = 0; i < 9; i++) begin
         applyStimulus((i < 2) ? 8'h11 : 8'h22, 1'b1, 1'b0, 1'b0);
         if (i == 5) checkOutput("restart_wait", 32'(outbus), 32'h00);
         if (i == 6) begin
            checkOutput("restart_out", 32'(outbus), 32'h22);
            checkOutput("restart_upd", 32'(upd_pulse), 32'h1);
         end
      end
      checkOutput("restart_glitch", 32'(glitch_cnt), 32'h02);
      checkOutput("restart_no_11", 32'(saw_11), 32'h0);

      // force_ld with en=0: value changes, then repeat with unchanged value
      applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
      checkOutput("force_pre", 32'(outbus), 32'h22);
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
      checkOutput("force_out", 32'(outbus), 32'hFF);
      checkOutput("force_upd", 32'(upd_pulse), 32'h1);
      applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);
      checkOutput("force_upd_fall", 32'(upd_pulse), 32'h0);
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
      checkOutput("force_same_upd", 32'(upd_pulse), 32'h0);
      checkOutput("force_same_out", 32'(outbus), 32'hFF);

      // en dropping mid-qualification, then restart from count 1
      for (int i = 0; i < 7; i++) begin
         applyStimulus(8'h00, (i != 2), 1'b0, 1'b0);
         if (i == 1) checkOutput("en_qual", 32'(qualifying), 32'h1);
         if (i == 2) checkOutput("en_idle", 32'(qualifying), 32'h0);
         if (i == 5) checkOutput("en_wait", 32'(outbus), 32'hFF);
         if (i == 6) checkOutput("en_accept", 32'(outbus), 32'h00);
      end
      checkOutput("en_no_glitch", 32'(glitch_cnt), 32'h02);

      // Saturation: 300 single-cycle glitches
      for (int g = 0; g < 300; g++) begin
         applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
         applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
         applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("sat_255", 32'(glitch_cnt), 32'hFF);

      // Clear coinciding with an abort
      applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h00, 1'b1, 1'b0, 1'b1);
      checkOutput("clr_wins", 32'(glitch_cnt), 32'h00);

      // Reset mid-qualification
      for (int i = 0; i < 6; i++) applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_rst_out", 32'(outbus), 32'h5A);
      for (int i = 0; i < 3; i++) applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
      checkOutput("pre_rst_qual", 32'(qualifying), 32'h1);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_out", 32'(outbus), 32'h00);
      checkOutput("midrst_qual", 32'(qualifying), 32'h0);
      checkOutput("midrst_upd", 32'(upd_pulse), 32'h0);
      en = 1'b0;
      inbus = 8'h00;

      // STABLE_CYCLES=1: a value changing every cycle is forwarded every cycle
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 12; j++) begin
         logic [7:0] v;
         logic [7:0] want;
         v = 8'h10 + 8'(j);
         inbus_f = v;
         fast_q.push_back(v);
         @(posedge clk);
         #1;
         if (j >= 1) begin
            want = fast_q.pop_front();
            checkOutput("fast_out", 32'(outbus_f), 32'(want));
            checkOutput("fast_upd", 32'(upd_f), 32'h1);
         end
      end

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
